// File: rtl/bus_mem_responder.sv
// Memory-side responder for the L1/bus coherence interface.
// Accepts R_REQ / RFO_BCAST / WB_REQ from the bus, runs one valid/ready
// transaction on the memory port and returns a single MEM_RESP or MEM_RESP_S.
// All outputs are registered: the comb process computes next-cycle output
// values alongside the next state, and the state register latches both.
module bus_mem_responder #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int MSG_BITS        = 4,
    parameter int BUS_OFFSET_BITS = 2,
    parameter int BUS_WIDTH       = (1 << BUS_OFFSET_BITS) * DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MSG_BITS-1:0]     bus_msg_in,
    input  logic [ADDRESS_BITS-1:0] bus_address_in,
    input  logic [BUS_WIDTH-1:0]    bus_data_in,
    input  logic                    shared,
    output logic [MSG_BITS-1:0]     bus_msg_out,
    output logic [ADDRESS_BITS-1:0] bus_address_out,
    output logic [BUS_WIDTH-1:0]    bus_data_out,
    output logic                    busy,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [BUS_WIDTH-1:0]    mem_data_out,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [BUS_WIDTH-1:0]    mem_data_in
);
    // Bus message encodings shared with the cache bus wrapper.
    localparam logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0);
    localparam logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(1);
    localparam logic [MSG_BITS-1:0] RFO_BCAST  = MSG_BITS'(2);
    localparam logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(3);
    localparam logic [MSG_BITS-1:0] MEM_RESP   = MSG_BITS'(4);
    localparam logic [MSG_BITS-1:0] MEM_RESP_S = MSG_BITS'(5);

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, RESP, DRAIN} state_t;

    // Request as latched from the bus in IDLE.
    typedef struct packed {
        logic [MSG_BITS-1:0]     msg;
        logic [ADDRESS_BITS-1:0] addr;
        logic                    shared;
    } req_t;

    state_t                  state, state_n;
    req_t                    req, req_n;
    logic [MSG_BITS-1:0]     msg_n;
    logic [ADDRESS_BITS-1:0] addr_n, maddr_n;
    logic [BUS_WIDTH-1:0]    data_n, mdata_n;
    logic                    rd_n, wr_n;

    // Next state plus next values of every registered output.
    always_comb begin
        state_n = state;
        req_n   = req;
        msg_n   = NO_REQ;
        addr_n  = '0;
        data_n  = '0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        maddr_n = mem_address;
        mdata_n = mem_data_out;
        unique case (state)
            IDLE: begin
                if (bus_msg_in == R_REQ || bus_msg_in == RFO_BCAST || bus_msg_in == WB_REQ) begin
                    req_n   = '{msg: bus_msg_in, addr: bus_address_in, shared: shared};
                    state_n = MEM_REQ;
                    rd_n    = (bus_msg_in != WB_REQ);
                    wr_n    = (bus_msg_in == WB_REQ);
                    maddr_n = bus_address_in;
                    mdata_n = (bus_msg_in == WB_REQ) ? bus_data_in : '0;
                end
            end
            MEM_REQ: begin
                // Command is held until memory accepts it; a coincident
                // mem_valid is deliberately ignored here.
                if (mem_ready) begin
                    state_n = MEM_WAIT;
                end else begin
                    rd_n = mem_read;
                    wr_n = mem_write;
                end
            end
            MEM_WAIT: begin
                if (mem_valid) begin
                    state_n = RESP;
                    addr_n  = req.addr;
                    msg_n   = (req.msg == R_REQ && req.shared) ? MEM_RESP_S : MEM_RESP;
                    data_n  = (req.msg == WB_REQ) ? '0 : mem_data_in;
                end
            end
            RESP: begin
                state_n = DRAIN;
            end
            DRAIN: begin
                // Wait for the requester to drop or change its request so it
                // is not accepted a second time.
                if (bus_msg_in != req.msg || bus_address_in != req.addr)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, latched request and registered outputs; reset abandons any transaction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            req             <= '0;
            bus_msg_out     <= NO_REQ;
            bus_address_out <= '0;
            bus_data_out    <= '0;
            busy            <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_data_out    <= '0;
        end else begin
            state           <= state_n;
            req             <= req_n;
            bus_msg_out     <= msg_n;
            bus_address_out <= addr_n;
            bus_data_out    <= data_n;
            busy            <= (state_n != IDLE);
            mem_read        <= rd_n;
            mem_write       <= wr_n;
            mem_address     <= maddr_n;
            mem_data_out    <= mdata_n;
        end
    end
endmodule
